// File: rtl/nrs_ls_estimator.sv
`default_nettype none
// ============================================================================
// Module      : nrs_ls_estimator
// Description : Least-squares channel estimator for a stream of received NRS
//               resource elements. Two-stage pipeline with a slot-control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module nrs_ls_estimator #(
    parameter int WIDTH_REG     = 16,
    parameter int LINES         = $clog2(WIDTH_REG),
    parameter int NRS_WIDTH_R_I = 16,
    parameter int IQ_WIDTH      = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       slot_start,
    input  logic                       nrs_ready,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IQ_WIDTH-1:0] in_re,
    input  logic signed [IQ_WIDTH-1:0] in_im,
    output logic [LINES-1:0]           rd_addr_est,
    input  logic [NRS_WIDTH_R_I-1:0]   nrs_est,
    output logic                       out_valid,
    output logic signed [IQ_WIDTH:0]   h_re,
    output logic signed [IQ_WIDTH:0]   h_im,
    output logic [LINES-1:0]           out_idx,
    output logic                       slot_done,
    output logic                       overflow
);

    localparam int              OW       = IQ_WIDTH + 1;
    localparam logic [LINES-1:0] LAST_IDX = LINES'(WIDTH_REG - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                    state_q,     state_d;
    logic [LINES-1:0]          cnt_q,       cnt_d;
    logic                      overflow_q,  overflow_d;
    logic                      in_ready_q,  in_ready_d;
    logic                      s1_valid_q,  s1_valid_d;
    logic signed [IQ_WIDTH-1:0] s1_re_q,    s1_re_d;
    logic signed [IQ_WIDTH-1:0] s1_im_q,    s1_im_d;
    logic [LINES-1:0]          s1_idx_q,    s1_idx_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [OW-1:0]      h_re_q,      h_re_d;
    logic signed [OW-1:0]      h_im_q,      h_im_d;
    logic [LINES-1:0]          out_idx_q,   out_idx_d;
    logic                      slot_done_q, slot_done_d;

    logic                      w_accept;
    logic                      w_sr_neg;
    logic                      w_si_neg;
    logic signed [OW-1:0]      w_re_x;
    logic signed [OW-1:0]      w_im_x;
    logic signed [OW-1:0]      w_re_sr;
    logic signed [OW-1:0]      w_im_sr;
    logic signed [OW-1:0]      w_re_si;
    logic signed [OW-1:0]      w_im_si;
    logic                      unused_nrs_bits;

    // slot_start wins over a coincident sample, so it blocks acceptance
    assign w_accept = in_valid & in_ready_q & ~slot_start;

    // Only the sign bit of each NRS half matters for a QPSK reference
    assign w_sr_neg        = nrs_est[NRS_WIDTH_R_I-1];
    assign w_si_neg        = nrs_est[NRS_WIDTH_R_I/2-1];
    assign unused_nrs_bits = ^nrs_est;

    assign w_re_x  = {s1_re_q[IQ_WIDTH-1], s1_re_q};
    assign w_im_x  = {s1_im_q[IQ_WIDTH-1], s1_im_q};
    assign w_re_sr = w_sr_neg ? -w_re_x : w_re_x;
    assign w_im_sr = w_sr_neg ? -w_im_x : w_im_x;
    assign w_re_si = w_si_neg ? -w_re_x : w_re_x;
    assign w_im_si = w_si_neg ? -w_im_x : w_im_x;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        overflow_d  = overflow_q;
        s1_valid_d  = 1'b0;
        s1_re_d     = s1_re_q;
        s1_im_d     = s1_im_q;
        s1_idx_d    = s1_idx_q;
        out_valid_d = 1'b0;
        slot_done_d = 1'b0;
        h_re_d      = h_re_q;
        h_im_d      = h_im_q;
        out_idx_d   = out_idx_q;

        if (slot_start) begin
            cnt_d      = '0;
            overflow_d = 1'b0;
            state_d    = nrs_ready ? ST_RUN : ST_WAIT_RDY;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_WAIT_RDY: begin
                    if (nrs_ready) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (cnt_q == LAST_IDX) begin
                            cnt_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + LINES'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (in_valid) overflow_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase

            if (w_accept) begin
                s1_valid_d = 1'b1;
                s1_re_d    = in_re;
                s1_im_d    = in_im;
                s1_idx_d   = cnt_q;
            end

            // A stage-1 entry is discarded when a new slot starts underneath it
            if (s1_valid_q) begin
                out_valid_d = 1'b1;
                h_re_d      = w_re_sr + w_im_si;
                h_im_d      = w_im_sr - w_re_si;
                out_idx_d   = s1_idx_q;
                slot_done_d = (s1_idx_q == LAST_IDX);
            end
        end

        in_ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            s1_idx_q    <= '0;
            out_valid_q <= 1'b0;
            h_re_q      <= '0;
            h_im_q      <= '0;
            out_idx_q   <= '0;
            slot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            s1_valid_q  <= s1_valid_d;
            s1_re_q     <= s1_re_d;
            s1_im_q     <= s1_im_d;
            s1_idx_q    <= s1_idx_d;
            out_valid_q <= out_valid_d;
            h_re_q      <= h_re_d;
            h_im_q      <= h_im_d;
            out_idx_q   <= out_idx_d;
            slot_done_q <= slot_done_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign rd_addr_est = s1_idx_q;
    assign out_valid   = out_valid_q;
    assign h_re        = h_re_q;
    assign h_im        = h_im_q;
    assign out_idx     = out_idx_q;
    assign slot_done   = slot_done_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire
